logic_unit_seq: RTL and testbench
=================================

Name: logic_unit_seq

Overview:
- Parametrised, registered successor to the 1-bit logic unit.
- Operates on WIDTH-bit operands and defines all 8 opcodes: AND, OR, XOR, NOT, SHL, SHR, ROL, ROR.
- Shifts and rotates run iteratively, one bit position per cycle. Logic ops finish in one cycle.
- Sits between the operand/decode stage and the writeback mux, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 2.
- AMT_W, $clog2(WIDTH), width of the shift-amount field taken from b[AMT_W-1:0]; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  operand A; also the value shifted/rotated.
- b  input  WIDTH  operand B; for shift ops, b[AMT_W-1:0] is the amount and upper bits are ignored.
- opsel  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 SHL, 5 SHR (logical), 6 ROL, 7 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result.
- out_zero  output  1  out_data == 0.
- out_carry  output  1  last bit shifted/rotated out.

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- Reset (rst_n low, async): state=IDLE, out_data=0, out_zero=0, out_carry=0, out_valid=0, shift counter=0. in_ready=1, since it is decoded from IDLE.
- Outputs:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - out_data/out_zero/out_carry are registered and held stable throughout DONE.
- Accept: in_valid && in_ready at a rising edge (edge t0).
  - Logic op (opsel 0..3): result computed and registered at t0; carry=0; next state DONE. Latency 1 (out_valid high in the cycle after t0).
  - Shift op with amount 0: result=a, carry=0, next state DONE. Latency 1.
  - Shift op with amount k>0: a loaded into the working register and counter=k at t0; next state SHIFT.
- SHIFT state:
  - Each edge applies one 1-bit step and decrements the counter.
  - carry = bit leaving the register on that step (SHL: MSB; SHR: LSB; ROL: MSB, which re-enters at LSB; ROR: LSB, which re-enters at MSB).
  - On the edge where the counter goes 1->0, go to DONE. Total latency k+1 edges from t0.
- DONE state:
  - Hold all outputs until out_ready.
  - out_valid && out_ready at an edge -> IDLE; out_valid deasserts next cycle.
  - No accept in the same cycle as the result handoff: throughput is at most 1 op per (latency+1) cycles.
- out_zero is computed from the final result when entering DONE, for all ops.
- in_valid, a, b, opsel are ignored outside IDLE. Operands need not be held after acceptance.
- out_ready is ignored outside DONE.
- Reset mid-SHIFT or mid-DONE aborts the operation; the result is discarded and the block returns to reset values immediately.
- No X or Z on any output for any opcode. All 8 opcodes are defined.

Decomposition:
- Package logic_unit_pkg holds:
  - op_e enum (3-bit: OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_ROL, OP_ROR).
  - state_e enum (IDLE, SHIFT, DONE).
  - Helper function is_shift(op_e).
- One combinational sub-module, shift_step, is natural:
  - Inputs: WIDTH-bit value and op.
  - Outputs: value after a 1-bit SHL/SHR/ROL/ROR step, plus the bit shifted out.
  - The top level holds the FSM, counter and result registers.

Test Plan (WIDTH=8):
1. Reset and all logic ops. Assert rst_n=0 -> outputs 0, in_ready=1. Release, then apply a=0xC5, b=0x3A with opsel 0/1/2/3 and out_ready=1 -> out_data 0x00 (out_zero=1), 0xFF, 0xFF, 0x3A. Each result has carry=0, out_valid exactly 1 cycle after accept, and in_ready back to 1 the cycle after handoff.
2. Shift/rotate latency and values:
   - SHL a=0x81, b=1 -> 0x02, carry=1, out_valid 2 edges after accept.
   - SHR a=0x81, b=3 -> 0x10, carry=0, latency 4.
   - ROL a=0x81, b=4 -> 0x18, carry=0, latency 5.
   - ROR a=0x01, b=1 -> 0x80, carry=1.
3. Amount boundaries:
   - SHL a=0x5A, b=0 -> 0x5A, carry=0, latency 1.
   - SHR a=0x80, b=7 -> 0x01, latency 8.
   - SHL a=0x5A, b=0xF8 (amount 0, upper bits ignored) -> 0x5A.
4. Backpressure: complete any op with out_ready=0 for 5 cycles -> out_valid=1 and out_data/flags stable; in_ready=0; in_valid pulses with new operands are ignored. Raise out_ready -> single handoff, then IDLE.
5. Reset mid-operation: start SHL a=0xFF, b=6. Drop rst_n asynchronously (between edges) on the 3rd SHIFT cycle -> out_valid=0, out_data=0 immediately, in_ready=1. After release, a fresh AND a=0x0F, b=0xFF -> 0x0F.
6. Back-to-back random: 1000 random ops with random in_valid/out_ready -> results match a reference model, with no lost or duplicated results.

Source files
------------

// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_pkg
// Brief  : Shared types and helpers for the sequential logic unit.
//          op_e    - 3-bit opcode encoding (matches the opsel port)
//          state_e - control FSM states
//          is_shift() - true for the four iterative shift/rotate opcodes
// Rev    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_ROL = 3'd6,
    OP_ROR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shift/rotate opcodes all live in the upper half of the encoding.
  function automatic logic is_shift(input op_e op);
    logic [2:0] v;
    v = op;
    return v[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_seq_shift_step.sv
`default_nettype none
// ============================================================================
// Module : shift_step
// Brief  : Combinational single-bit shift/rotate step.
// Ports  : val_i [WIDTH] - value before the step
//          op_i  [3]     - opcode; non-shift opcodes pass val_i through
//          val_o [WIDTH] - value after one SHL/SHR/ROL/ROR step
//          bit_o         - bit that left the register on this step
// Rev    : 1.0 - initial release
// ============================================================================
module shift_step
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] val_o,
  output logic             bit_o
);

  always_comb begin
    val_o = val_i;
    bit_o = 1'b0;
    case (op_i)
      OP_SHL: begin
        val_o = {val_i[WIDTH-2:0], 1'b0};
        bit_o = val_i[WIDTH-1];
      end
      OP_SHR: begin
        val_o = {1'b0, val_i[WIDTH-1:1]};
        bit_o = val_i[0];
      end
      OP_ROL: begin
        val_o = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
        bit_o = val_i[WIDTH-1];
      end
      OP_ROR: begin
        val_o = {val_i[0], val_i[WIDTH-1:1]};
        bit_o = val_i[0];
      end
      default: begin
        val_o = val_i;
        bit_o = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_seq
// Brief  : Registered WIDTH-bit logic unit with iterative shifts/rotates.
//          Logic ops complete in one cycle; shifts/rotates take one cycle
//          per bit position. valid/ready handshake on both sides.
// Ports  : clk, rst_n (async, active-low)
//          in_valid / in_ready  - operand handshake (ready only in IDLE)
//          a, b [WIDTH], opsel [3] - operands and opcode
//          out_valid / out_ready - result handshake (valid only in DONE)
//          out_data [WIDTH], out_zero, out_carry - registered result
// Rev    : 1.0 - initial release
// ============================================================================
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_carry
);

  localparam int AMT_W = $clog2(WIDTH);

  state_e           state_q;
  op_e              op_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             carry_q;

  op_e              op_in;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  assign op_in = op_e'(opsel);
  assign amt   = b[AMT_W-1:0];

  always_comb begin
    logic_res = a;
    case (op_in)
      OP_AND:  logic_res = a & b;
      OP_OR:   logic_res = a | b;
      OP_XOR:  logic_res = a ^ b;
      OP_NOT:  logic_res = ~a;
      default: logic_res = a;
    endcase
  end

  // data_q doubles as the working register while in SHIFT.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .val_i (data_q),
    .op_i  (op_q),
    .val_o (step_val),
    .bit_o (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op_in;
            carry_q <= 1'b0;
            if (!is_shift(op_in)) begin
              data_q  <= logic_res;
              zero_q  <= (logic_res == '0);
              state_q <= DONE;
            end else if (amt == '0) begin
              data_q  <= a;
              zero_q  <= (a == '0);
              state_q <= DONE;
            end else begin
              data_q  <= a;
              zero_q  <= 1'b0;
              cnt_q   <= amt;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q  <= step_val;
          carry_q <= step_bit;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            zero_q  <= (step_val == '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_zero  = zero_q;
  assign out_carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_logic_unit_seq
// Brief  : Scoreboard bench for logic_unit_seq (WIDTH=8). The driver pushes
//          the expected result at acceptance; a monitor pops and compares on
//          each out_valid && out_ready handoff.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_seq;

  typedef struct packed {
    logic [7:0] d;
    logic       z;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] opsel = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_carry;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_or = 1'b0;

  logic_unit_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opsel     (opsel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic c);
    exp_t e;
    e.d = d;
    e.z = (d == 8'h00);
    e.c = c;
    return e;
  endfunction

  // Behavioural reference for the random phase.
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] op);
    int         k;
    logic [7:0] d;
    logic       c;
    k = int'(ib[2:0]);
    c = 1'b0;
    case (op)
      3'd0: d = ia & ib;
      3'd1: d = ia | ib;
      3'd2: d = ia ^ ib;
      3'd3: d = ~ia;
      3'd4: begin d = ia << k; if (k != 0) c = ia[8-k]; end
      3'd5: begin d = ia >> k; if (k != 0) c = ia[k-1]; end
      3'd6: begin d = (ia << k) | (ia >> (8-k)); if (k != 0) c = d[0]; end
      default: begin d = (ia >> k) | (ia << (8-k)); if (k != 0) c = d[7]; end
    endcase
    return mk(d, c);
  endfunction

  // Monitor: one comparison set per result handoff.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h required none", out_data);
      end else begin
        e = sb.pop_front();
        chk("result_data", 32'(out_data), 32'(e.d));
        chk("result_zero", 32'(out_zero), 32'(e.z));
        chk("result_carry", 32'(out_carry), 32'(e.c));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_or) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Caller enters at posedge+1. lat>0 also checks latency and, with
  // out_ready high, the return to IDLE after the handoff.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] op,
                       input bit push, input exp_t e, input int lat);
    bit acc;
    bit ok;
    int n;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    opsel = op;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
    if (push) sb.push_back(e);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    opsel = 3'($urandom);
    if (lat > 0) begin
      n = 1;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("latency", 32'(n), 32'(lat));
      if (out_ready) begin
        @(posedge clk);
        #1;
        chk("idle_after_handoff", {30'd0, out_valid, in_ready}, 32'b01);
      end
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] rop;
    int         w;

    // 1. reset and logic ops
    #3 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_zero", 32'(out_zero), 32'd0);
    chk("reset_out_carry", 32'(out_carry), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(8'hC5, 8'h3A, 3'd0, 1'b1, mk(8'h00, 1'b0), 1);
    issue(8'hC5, 8'h3A, 3'd1, 1'b1, mk(8'hFF, 1'b0), 1);
    issue(8'hC5, 8'h3A, 3'd2, 1'b1, mk(8'hFF, 1'b0), 1);
    issue(8'hC5, 8'h3A, 3'd3, 1'b1, mk(8'h3A, 1'b0), 1);

    // 2. shift/rotate values and latency
    issue(8'h81, 8'h01, 3'd4, 1'b1, mk(8'h02, 1'b1), 2);
    issue(8'h81, 8'h03, 3'd5, 1'b1, mk(8'h10, 1'b0), 4);
    issue(8'h81, 8'h04, 3'd6, 1'b1, mk(8'h18, 1'b0), 5);
    issue(8'h01, 8'h01, 3'd7, 1'b1, mk(8'h80, 1'b1), 2);

    // 3. amount boundaries
    issue(8'h5A, 8'h00, 3'd4, 1'b1, mk(8'h5A, 1'b0), 1);
    issue(8'h80, 8'h07, 3'd5, 1'b1, mk(8'h01, 1'b0), 8);
    issue(8'h5A, 8'hF8, 3'd4, 1'b1, mk(8'h5A, 1'b0), 1);

    // 4. backpressure
    out_ready = 1'b0;
    issue(8'h33, 8'h0F, 3'd2, 1'b1, mk(8'h3C, 1'b0), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_data", 32'(out_data), 32'h3C);
      chk("bp_flags", {30'd0, out_zero, out_carry}, 32'd0);
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      opsel = 3'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    #1;
    chk("bp_stays_idle", {30'd0, out_valid, in_ready}, 32'b01);

    // 5. reset during SHIFT
    issue(8'hFF, 8'h06, 3'd4, 1'b0, mk(8'h00, 1'b0), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    chk("abort_out_carry", 32'(out_carry), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(8'h0F, 8'hFF, 3'd0, 1'b1, mk(8'h0F, 1'b0), 1);

    // 6. random traffic with random backpressure
    rand_or = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom_range(0, 2);
      for (int j = 0; j < w; j++) begin
        @(posedge clk);
        #1;
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = 3'($urandom);
      issue(ra, rb, rop, 1'b1, model(ra, rb, rop), 0);
    end
    rand_or = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
